button_debounce: RTL and testbench

- Upstream conditioning stage for the push-button counter path.
- Takes NUM_BTN raw, bouncy, active-low board buttons and produces clean, registered outputs per channel:
  - a debounced level
  - a single-cycle press pulse
  - a single-cycle release pulse
  - an optional auto-repeat step pulse
- The step pulse drives the downstream LED counter as a one-cycle enable, replacing the direct button-as-clock path.

---
 rtl/button_debounce_pkg.sv | 18 +
 rtl/button_debounce_if.sv | 26 ++
 rtl/button_debounce_channel.sv | 127 ++++++++++++
 rtl/button_debounce.sv | 32 +++
 tb/tb_button_debounce.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared types, constants and helpers for the button debouncer
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        CHK_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        CHK_RELEASE = 2'd3
    } btn_state_e;

    // Board buttons pull low when pressed
    localparam logic BTN_ACTIVE = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - raw button inputs and conditioned per-channel outputs
interface button_debounce_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] release_pulse;
    logic [NUM_BTN-1:0] step_pulse;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  step_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output step_pulse
    );
endinterface

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one channel: synchronizer, debounce FSM and auto-repeat counter
module button_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);
    import button_pkg::*;

    localparam int DEB_W = max_int(1, $clog2(DEBOUNCE_CYCLES));
    localparam int REP_W = max_int(1, $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)));

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic             sync_q1, sync_q2;
    logic             pressed;
    btn_state_e       state, state_n;
    logic [DEB_W-1:0] deb_cnt, deb_n;
    logic [REP_W-1:0] rep_cnt, rep_n;
    logic             first_rep, first_n;
    logic             level_n, press_n, release_n, step_n;

    // Two-flop synchronizer; resets to the released level so reset never looks like a press
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync_q1 <= ~BTN_ACTIVE;
            sync_q2 <= ~BTN_ACTIVE;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed = (sync_q2 == BTN_ACTIVE);

    // State, counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            rep_cnt       <= '0;
            first_rep     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            deb_cnt       <= deb_n;
            rep_cnt       <= rep_n;
            first_rep     <= first_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            step_pulse    <= step_n;
        end
    end

    // Debounce/repeat decisions; the repeat counter is held across a rejected release bounce
    always_comb begin
        state_n   = state;
        deb_n     = deb_cnt;
        rep_n     = rep_cnt;
        first_n   = first_rep;
        press_n   = 1'b0;
        release_n = 1'b0;
        step_n    = 1'b0;
        case (state)
            RELEASED: begin
                if (pressed) begin
                    deb_n   = '0;
                    state_n = CHK_PRESS;
                end
            end
            CHK_PRESS: begin
                if (!pressed) begin
                    state_n = RELEASED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                    step_n  = 1'b1;
                    rep_n   = '0;
                    first_n = 1'b1;
                end else begin
                    deb_n = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    deb_n   = '0;
                    state_n = CHK_RELEASE;
                end else if (REPEAT_EN != 0) begin
                    if (rep_cnt == (first_rep ? REP_FIRST : REP_NEXT)) begin
                        step_n  = 1'b1;
                        rep_n   = '0;
                        first_n = 1'b0;
                    end else begin
                        rep_n = rep_cnt + 1'b1;
                    end
                end
            end
            CHK_RELEASE: begin
                if (pressed) begin
                    state_n = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n   = RELEASED;
                    release_n = 1'b1;
                end else begin
                    deb_n = deb_cnt + 1'b1;
                end
            end
            default: state_n = RELEASED;
        endcase
        level_n = (state_n == PRESSED) || (state_n == CHK_RELEASE);
    end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - NUM_BTN independent debounced button channels
module button_debounce #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    button_debounce_if.slave  bif
);

    // One self-contained channel per button
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .btn_in        (bif.btn_in[i]),
            .btn_level     (bif.btn_level[i]),
            .press_pulse   (bif.press_pulse[i]),
            .release_pulse (bif.release_pulse[i]),
            .step_pulse    (bif.step_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    button_debounce_if #(.NUM_BTN(2)) bif_a ();
    button_debounce_if #(.NUM_BTN(2)) bif_b ();

    button_debounce #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .bif    (bif_a.slave)
    );

    button_debounce #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bif    (bif_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [1:0] v);
        bif_a.btn_in = v;
        bif_b.btn_in = v;
    endtask

    task automatic release_all();
        set_btn(2'b11);
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [1:0] exp;
        rst = 1'b0;
        set_btn(2'b00);
        repeat (3) tick();
        checks++;
        if ({bif_a.btn_level, bif_a.press_pulse, bif_a.release_pulse, bif_a.step_pulse} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs_a got %h want 00",
                     {bif_a.btn_level, bif_a.press_pulse, bif_a.release_pulse, bif_a.step_pulse});
        end
        checks++;
        if ({bif_b.btn_level, bif_b.press_pulse, bif_b.release_pulse, bif_b.step_pulse} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs_b got %h want 00",
                     {bif_b.btn_level, bif_b.press_pulse, bif_b.release_pulse, bif_b.step_pulse});
        end
        rst = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp = (e == 6) ? 2'b11 : 2'b00;
            checks++;
            if (bif_a.press_pulse !== exp) begin
                errors++;
                $display("FAIL reset_press edge %0d got %b want %b", e, bif_a.press_pulse, exp);
            end
            checks++;
            if (bif_a.btn_level !== exp) begin
                errors++;
                $display("FAIL reset_level edge %0d got %b want %b", e, bif_a.btn_level, exp);
            end
        end
        set_btn(2'b11);
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp = (e == 6) ? 2'b11 : 2'b00;
            checks++;
            if (bif_a.release_pulse !== exp) begin
                errors++;
                $display("FAIL reset_release edge %0d got %b want %b", e, bif_a.release_pulse, exp);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        logic exp;
        set_btn(2'b10);
        for (int e = 0; e <= 7; e++) begin
            tick();
            exp = (e == 6);
            checks++;
            if (bif_a.press_pulse[0] !== exp || bif_a.step_pulse[0] !== exp) begin
                errors++;
                $display("FAIL press_pulse edge %0d got press=%b step=%b want %b",
                         e, bif_a.press_pulse[0], bif_a.step_pulse[0], exp);
            end
            checks++;
            if (bif_a.btn_level[0] !== (e >= 6)) begin
                errors++;
                $display("FAIL press_level edge %0d got %b want %b", e, bif_a.btn_level[0], (e >= 6));
            end
            checks++;
            if (bif_a.press_pulse[1] !== 1'b0 || bif_a.btn_level[1] !== 1'b0) begin
                errors++;
                $display("FAIL press_other_chan edge %0d got press=%b level=%b want 0",
                         e, bif_a.press_pulse[1], bif_a.btn_level[1]);
            end
        end
        set_btn(2'b11);
        for (int e = 0; e <= 7; e++) begin
            tick();
            exp = (e == 6);
            checks++;
            if (bif_a.release_pulse[0] !== exp || bif_a.press_pulse[0] !== 1'b0) begin
                errors++;
                $display("FAIL release_pulse edge %0d got rel=%b press=%b want rel=%b press=0",
                         e, bif_a.release_pulse[0], bif_a.press_pulse[0], exp);
            end
            checks++;
            if (bif_a.btn_level[0] !== (e < 6)) begin
                errors++;
                $display("FAIL release_level edge %0d got %b want %b", e, bif_a.btn_level[0], (e < 6));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        pat = 12'b1111_1100_1000;
        for (int i = 0; i < 12; i++) begin
            set_btn({1'b1, pat[i]});
            tick();
            checks++;
            if (bif_a.press_pulse[0] !== 1'b0 || bif_a.btn_level[0] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_press step %0d got press=%b level=%b want 0",
                         i, bif_a.press_pulse[0], bif_a.btn_level[0]);
            end
        end
        set_btn(2'b10);
        repeat (7) tick();
        checks++;
        if (bif_a.btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_setup_level got %b want 1", bif_a.btn_level[0]);
        end
        for (int i = 0; i < 12; i++) begin
            set_btn({1'b1, ~pat[i]});
            tick();
            checks++;
            if (bif_a.release_pulse[0] !== 1'b0 || bif_a.btn_level[0] !== 1'b1) begin
                errors++;
                $display("FAIL bounce_release step %0d got rel=%b level=%b want rel=0 level=1",
                         i, bif_a.release_pulse[0], bif_a.btn_level[0]);
            end
        end
        release_all();
    endtask

    task automatic test_auto_repeat();
        logic exp;
        set_btn(2'b10);
        for (int e = 0; e < 40; e++) begin
            tick();
            exp = (e == 6) || (e >= 16 && ((e - 16) % 3) == 0);
            checks++;
            if (bif_a.step_pulse[0] !== exp) begin
                errors++;
                $display("FAIL repeat_step edge %0d got %b want %b", e, bif_a.step_pulse[0], exp);
            end
            checks++;
            if (bif_a.press_pulse[0] !== (e == 6)) begin
                errors++;
                $display("FAIL repeat_press edge %0d got %b want %b", e, bif_a.press_pulse[0], (e == 6));
            end
        end
        set_btn(2'b11);
        for (int e = 0; e <= 6; e++) begin
            tick();
            checks++;
            if (bif_a.release_pulse[0] !== (e == 6)) begin
                errors++;
                $display("FAIL repeat_release edge %0d got %b want %b", e, bif_a.release_pulse[0], (e == 6));
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_repeat_disabled();
        set_btn(2'b10);
        for (int e = 0; e < 40; e++) begin
            tick();
            checks++;
            if (bif_b.step_pulse[0] !== (e == 6)) begin
                errors++;
                $display("FAIL norepeat_step edge %0d got %b want %b", e, bif_b.step_pulse[0], (e == 6));
            end
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        set_btn(2'b10);
        repeat (7) tick();
        checks++;
        if (bif_a.btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup_level got %b want 1", bif_a.btn_level[0]);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({bif_a.btn_level, bif_a.press_pulse, bif_a.release_pulse, bif_a.step_pulse} !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs got %h want 00",
                     {bif_a.btn_level, bif_a.press_pulse, bif_a.release_pulse, bif_a.step_pulse});
        end
        for (int e = 0; e <= 7; e++) begin
            tick();
            checks++;
            if (bif_a.release_pulse[0] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_release edge %0d got %b want 0", e, bif_a.release_pulse[0]);
            end
            checks++;
            if (bif_a.press_pulse[0] !== (e == 6)) begin
                errors++;
                $display("FAIL midrst_press edge %0d got %b want %b", e, bif_a.press_pulse[0], (e == 6));
            end
        end
        release_all();
    endtask

    initial begin
        rst = 1'b0;
        set_btn(2'b11);
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_disabled();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
